// File: rtl/sms_timing_pkg.sv
// Shared types and helpers for the SMS memory-cycle timing ring.
package sms_timing_pkg;

  localparam int RING_LEN_DEFAULT = 20;
  localparam int PHASE_W_DEFAULT  = 5;

  typedef enum logic [1:0] {
    HALT     = 2'd0,
    RUN      = 2'd1,
    SINGLE   = 2'd2,
    STOPPING = 2'd3
  } ring_state_e;

  // Decodes a binary phase number into the ring's one-hot phase vector.
  function automatic logic [RING_LEN_DEFAULT-1:0] phase_to_onehot(
    input logic [PHASE_W_DEFAULT-1:0] ph
  );
    logic [RING_LEN_DEFAULT-1:0] oh;
    for (int i = 0; i < RING_LEN_DEFAULT; i++) begin
      oh[i] = (ph == PHASE_W_DEFAULT'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/sms_sync_edge.sv
// Brings the asynchronous oscillator into the clk domain and emits one
// clk-wide pulse per synchronised rising edge.
module sms_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic osc_i,
  output logic tick_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Synchroniser chain plus delayed copy of its output for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/sms_timing_ring_ctrl.sv
// 20-phase memory-cycle timing ring driven by the oscillator, with
// run / stop / single-cycle control that only halts on a cycle boundary.
module sms_timing_ring_ctrl
  import sms_timing_pkg::*;
#(
  parameter int RING_LEN    = RING_LEN_DEFAULT,
  parameter int PHASE_W     = PHASE_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               osc_in,
  input  logic               run_req,
  input  logic               stop_req,
  input  logic               single_req,
  output logic [PHASE_W-1:0] phase,
  output logic [RING_LEN-1:0] phase_oh,
  output logic               osc_tick,
  output logic               cycle_start,
  output logic               cycle_end,
  output logic               running,
  output logic               halted
);

  ring_state_e         state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d, phase_adv_s;
  logic [RING_LEN-1:0] phase_oh_q;
  logic                cycle_start_q, cycle_start_d;
  logic                cycle_end_q, cycle_end_d;
  logic                running_q, halted_q;
  logic                tick_s, at_last_s;

  sms_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .osc_i  (osc_in),
    .tick_o (tick_s)
  );

  assign at_last_s   = (phase_q == PHASE_W'(RING_LEN - 1));
  assign phase_adv_s = at_last_s ? '0 : phase_q + PHASE_W'(1);

  // Next-state, next-phase and boundary pulses; stop_req outranks run_req outranks single_req.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cycle_start_d = 1'b0;
    cycle_end_d   = 1'b0;
    case (state_q)
      HALT: begin
        phase_d = '0;
        if (stop_req) begin
          state_d = HALT;
        end else if (run_req) begin
          state_d = RUN;
        end else if (single_req) begin
          state_d = SINGLE;
        end else begin
          state_d = HALT;
        end
      end
      RUN: begin
        if (tick_s) begin
          phase_d     = phase_adv_s;
          cycle_end_d = at_last_s;
        end else begin
          phase_d = phase_q;
        end
        if (stop_req || !run_req) begin
          state_d = (tick_s && at_last_s) ? HALT : STOPPING;
        end else begin
          state_d       = RUN;
          cycle_start_d = tick_s && at_last_s;
        end
      end
      SINGLE, STOPPING: begin
        if (tick_s) begin
          phase_d     = phase_adv_s;
          cycle_end_d = at_last_s;
          if (!at_last_s) begin
            state_d = state_q;
          end else if (state_q == STOPPING && run_req && !stop_req) begin
            // Run re-requested at the boundary: continue without a halt gap.
            state_d       = RUN;
            cycle_start_d = 1'b1;
          end else begin
            state_d = HALT;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = HALT;
        phase_d = '0;
      end
    endcase
  end

  // State, phase and registered status/pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HALT;
      phase_q       <= '0;
      phase_oh_q    <= RING_LEN'(1);
      cycle_start_q <= 1'b0;
      cycle_end_q   <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_oh_q    <= phase_to_onehot(phase_d);
      cycle_start_q <= cycle_start_d;
      cycle_end_q   <= cycle_end_d;
      running_q     <= (state_d != HALT);
      halted_q      <= (state_d == HALT);
    end
  end

  assign phase       = phase_q;
  assign phase_oh    = phase_oh_q;
  assign osc_tick    = tick_s;
  assign cycle_start = cycle_start_q;
  assign cycle_end   = cycle_end_q;
  assign running     = running_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_sms_timing_ring_ctrl.sv
// Directed self-checking bench for the SMS timing ring controller.
module tb_sms_timing_ring_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        osc_in;
  logic        run_req;
  logic        stop_req;
  logic        single_req;
  logic [4:0]  phase;
  logic [19:0] phase_oh;
  logic        osc_tick;
  logic        cycle_start;
  logic        cycle_end;
  logic        running;
  logic        halted;

  int errors = 0;
  int checks = 0;
  int cs_cnt = 0;
  int ce_cnt = 0;

  sms_timing_ring_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .osc_in      (osc_in),
    .run_req     (run_req),
    .stop_req    (stop_req),
    .single_req  (single_req),
    .phase       (phase),
    .phase_oh    (phase_oh),
    .osc_tick    (osc_tick),
    .cycle_start (cycle_start),
    .cycle_end   (cycle_end),
    .running     (running),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally boundary pulses seen there.
  task automatic step();
    @(negedge clk);
    if (cycle_start === 1'b1) cs_cnt++;
    if (cycle_end === 1'b1) ce_cnt++;
  endtask

  // One full oscillator period: 5 clk high, 5 clk low, starting on a falling edge.
  task automatic osc_pulse();
    osc_in = 1'b1;
    repeat (5) step();
    osc_in = 1'b0;
    repeat (5) step();
  endtask

  task automatic chk_phase(input string tag, input int exp_ph);
    logic [19:0] exp_oh;
    exp_oh = 20'd1 << exp_ph;
    chk(tag, 32'(phase), 32'(exp_ph));
    chk({tag, "_oh"}, 32'(phase_oh), 32'(exp_oh));
  endtask

  initial begin
    rst_n      = 1'b0;
    osc_in     = 1'b0;
    run_req    = 1'b0;
    stop_req   = 1'b0;
    single_req = 1'b0;
    repeat (3) step();

    // Reset state
    chk_phase("rst_phase", 0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_cs", 32'(cycle_start), 32'd0);
    chk("rst_ce", 32'(cycle_end), 32'd0);
    chk("rst_tick", 32'(osc_tick), 32'd0);
    rst_n = 1'b1;
    step();

    // stop_req and run_req together in HALT: stays halted; ticks ignored
    stop_req = 1'b1;
    run_req  = 1'b1;
    step();
    stop_req = 1'b0;
    run_req  = 1'b0;
    step();
    chk("simul_halted", 32'(halted), 32'd1);
    osc_pulse();
    chk_phase("halt_ignores_tick", 0);

    // Run and sync latency on the first tick
    run_req = 1'b1;
    step();
    chk("run_running", 32'(running), 32'd1);
    chk("run_halted", 32'(halted), 32'd0);
    chk_phase("run_entry", 0);
    cs_cnt = 0;
    ce_cnt = 0;
    osc_in = 1'b1;
    step();
    chk("lat_tick_e1", 32'(osc_tick), 32'd0);
    step();
    chk("lat_tick_e2", 32'(osc_tick), 32'd1);
    chk_phase("lat_phase_e2", 0);
    step();
    chk("lat_tick_e3", 32'(osc_tick), 32'd0);
    chk_phase("lat_phase_e3", 1);
    repeat (2) step();
    osc_in = 1'b0;
    repeat (5) step();
    for (int k = 2; k <= 40; k++) begin
      osc_pulse();
      chk_phase($sformatf("run_k%0d", k), k % 20);
      if (k == 20) begin
        chk("run_cs_1cyc", 32'(cs_cnt), 32'd1);
        chk("run_ce_1cyc", 32'(ce_cnt), 32'd1);
      end
    end
    chk("run_cs_2cyc", 32'(cs_cnt), 32'd2);
    chk("run_ce_2cyc", 32'(ce_cnt), 32'd2);
    repeat (7) osc_pulse();
    chk_phase("run_at7", 7);

    // Async reset mid-cycle at phase 7
    ce_cnt = 0;
    #2 rst_n = 1'b0;
    #1;
    chk_phase("amid_rst_phase", 0);
    chk("amid_rst_halted", 32'(halted), 32'd1);
    chk("amid_rst_running", 32'(running), 32'd0);
    chk("amid_rst_ce", 32'(cycle_end), 32'd0);
    run_req = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("amid_rst_no_ce", 32'(ce_cnt), 32'd0);

    // Stop at phase 5: finish the cycle, then halt
    run_req = 1'b1;
    step();
    repeat (5) osc_pulse();
    chk_phase("stop_at5", 5);
    cs_cnt = 0;
    ce_cnt = 0;
    stop_req = 1'b1;
    run_req  = 1'b0;
    step();
    stop_req = 1'b0;
    chk("stopping_running", 32'(running), 32'd1);
    chk_phase("stopping_hold", 5);
    for (int k = 6; k <= 19; k++) begin
      osc_pulse();
      chk_phase($sformatf("stop_k%0d", k), k);
    end
    chk("stop_at19_running", 32'(running), 32'd1);
    osc_pulse();
    chk_phase("stop_end", 0);
    chk("stop_halted", 32'(halted), 32'd1);
    chk("stop_ce", 32'(ce_cnt), 32'd1);
    chk("stop_cs", 32'(cs_cnt), 32'd0);

    // Single cycle, with a dropped second single_req and an ignored stop_req
    single_req = 1'b1;
    step();
    single_req = 1'b0;
    chk("single_running", 32'(running), 32'd1);
    for (int k = 1; k <= 19; k++) begin
      osc_pulse();
      chk_phase($sformatf("single_k%0d", k), k);
      if (k == 3) begin
        single_req = 1'b1;
        step();
        single_req = 1'b0;
      end
      if (k == 10) begin
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
      end
    end
    chk("single_at19_running", 32'(running), 32'd1);
    osc_pulse();
    chk_phase("single_end", 0);
    chk("single_halted", 32'(halted), 32'd1);
    chk("single_ce", 32'(ce_cnt), 32'd2);
    chk("single_cs", 32'(cs_cnt), 32'd0);
    osc_pulse();
    chk_phase("single_no_requeue", 0);
    chk("single_stays_halted", 32'(halted), 32'd1);

    // stop_req coinciding with the wrap tick at phase 19 in RUN
    run_req = 1'b1;
    step();
    repeat (19) osc_pulse();
    chk_phase("coinc_at19", 19);
    cs_cnt = 0;
    ce_cnt = 0;
    osc_in = 1'b1;
    step();
    step();
    chk("coinc_tick", 32'(osc_tick), 32'd1);
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    run_req  = 1'b0;
    chk_phase("coinc_phase", 0);
    chk("coinc_halted", 32'(halted), 32'd1);
    chk("coinc_ce", 32'(ce_cnt), 32'd1);
    chk("coinc_cs", 32'(cs_cnt), 32'd0);
    repeat (3) step();
    osc_in = 1'b0;
    repeat (5) step();
    chk("coinc_still_halted", 32'(halted), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
